// File: rtl/sliding_window_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sliding_window_buffer_if: pixel stream in, 3x3 window stream out.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface sliding_window_buffer_if #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
);
  localparam int CXW = $clog2(IMAGE_WIDTH);
  localparam int CYW = $clog2(IMAGE_HEIGHT);

  logic           sof;
  logic           in_valid;
  logic [7:0]     in_pixel;
  logic           out_valid;
  logic [71:0]    pixel_values;
  logic [CXW-1:0] center_x;
  logic [CYW-1:0] center_y;

  modport master (
    output sof, in_valid, in_pixel,
    input  out_valid, pixel_values, center_x, center_y
  );

  modport slave (
    input  sof, in_valid, in_pixel,
    output out_valid, pixel_values, center_x, center_y
  );
endinterface
`default_nettype wire

// File: rtl/sliding_window_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sliding_window_buffer: two line buffers + 3x3 array, emits interior windows|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sliding_window_buffer #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  wire logic               clk,
  input  wire logic               reset,
  sliding_window_buffer_if.slave  bus
);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [71:0]   win_q, win_d;
  logic          out_valid_q, out_valid_d;
  logic [71:0]   pixel_values_q, pixel_values_d;
  logic [CW-1:0] center_x_q, center_x_d;
  logic [RW-1:0] center_y_q, center_y_d;

  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row;
  logic [7:0]    lb0_rd, lb1_rd;
  logic          win_ok;

  logic [7:0] lb0_mem [IMAGE_WIDTH];
  logic [7:0] lb1_mem [IMAGE_WIDTH];

  // sof only counts with in_valid, and then pins the pixel to (0,0)
  assign eff_col = (bus.sof && bus.in_valid) ? '0 : col_q;
  assign eff_row = (bus.sof && bus.in_valid) ? '0 : row_q;
  assign lb0_rd  = lb0_mem[eff_col];
  assign lb1_rd  = lb1_mem[eff_col];
  assign win_ok  = bus.in_valid && (eff_col >= CW'(2)) && (eff_row >= RW'(2));

  always_comb begin
    col_d          = col_q;
    row_d          = row_q;
    win_d          = win_q;
    out_valid_d    = win_ok;
    pixel_values_d = pixel_values_q;
    center_x_d     = center_x_q;
    center_y_d     = center_y_q;
    if (bus.in_valid) begin
      if (eff_col == COL_LAST) begin
        col_d = '0;
        row_d = (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end
      // each window row shifts left; the new right column is {LB1, LB0, pixel}
      win_d = {win_q[63:48], lb1_rd, win_q[39:24], lb0_rd, win_q[15:0], bus.in_pixel};
    end
    if (win_ok) begin
      pixel_values_d = win_d;
      center_x_d     = eff_col - CW'(1);
      center_y_d     = eff_row - RW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q          <= '0;
      row_q          <= '0;
      win_q          <= '0;
      out_valid_q    <= 1'b0;
      pixel_values_q <= '0;
      center_x_q     <= '0;
      center_y_q     <= '0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      win_q          <= win_d;
      out_valid_q    <= out_valid_d;
      pixel_values_q <= pixel_values_d;
      center_x_q     <= center_x_d;
      center_y_q     <= center_y_d;
    end
  end

  // Line buffers carry no reset; stale rows are masked by the row>=2 condition
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      lb0_mem[eff_col] <= bus.in_pixel;
      lb1_mem[eff_col] <= lb0_rd;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.pixel_values = pixel_values_q;
  assign bus.center_x     = center_x_q;
  assign bus.center_y     = center_y_q;
endmodule
`default_nettype wire
